// File: rtl/pdpu_posit_decoder_pipe.sv
// pdpu_posit_decoder_pipe
//   Multi-lane, two-stage pipelined posit decoder with valid/ready flow control.
//   Each lane unpacks an n-bit posit into sign, signed scale (k*2^es + e) and a
//   normalised mantissa {implicit bit, fraction}. Zero and NaR are flagged per
//   lane. All lanes share one handshake.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-high reset
//   flush_i      synchronous clear of both stage valid bits
//   in_valid_i   input beat valid
//   in_ready_o   block accepts a beat this cycle
//   operand_i    lane L at [L*n +: n]
//   out_valid_o  output beat valid
//   out_ready_i  consumer accepts the output beat
//   sign_o       per-lane sign
//   rg_exp_o     per-lane signed scale, EXP_WIDTH+1 bits each
//   mant_norm_o  per-lane {implicit bit, fraction}, MANT_WIDTH+1 bits each
//   is_zero_o    per-lane zero flag
//   is_nar_o     per-lane NaR flag
//   busy_o       any stage holds a valid beat
module pdpu_posit_decoder_pipe #(
  parameter  int unsigned n          = 16,
  parameter  int unsigned es         = 1,
  parameter  int unsigned LANES      = 4,
  localparam int unsigned nd         = $clog2(n - 1),
  localparam int unsigned EXP_WIDTH  = nd + es,
  localparam int unsigned MANT_WIDTH = n - es - 3
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 flush_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic [LANES*n-1:0]                   operand_i,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [LANES-1:0]                     sign_o,
  output logic [LANES*(EXP_WIDTH+1)-1:0]       rg_exp_o,
  output logic [LANES*(MANT_WIDTH+1)-1:0]      mant_norm_o,
  output logic [LANES-1:0]                     is_zero_o,
  output logic [LANES-1:0]                     is_nar_o,
  output logic                                 busy_o
);

  localparam int unsigned RW = $clog2(n);       // run length reaches n-1
  localparam int unsigned SW = EXP_WIDTH + 1;
  localparam int unsigned MW = MANT_WIDTH + 1;

  // Handshake: each stage advances when it is empty or the stage after it moves.
  logic s1_valid;
  logic s1_adv, s2_adv;

  assign s2_adv     = !out_valid_o || out_ready_i;
  assign s1_adv     = !s1_valid || s2_adv;
  assign in_ready_o = s1_adv;
  assign busy_o     = s1_valid | out_valid_o;

  // Stage 1 combinational: conditional negate and regime run count.
  logic [LANES-1:0]         sign_d, zero_d, nar_d, done_d;
  logic [LANES-1:0][n-2:0]  body_d;
  logic [LANES-1:0][RW-1:0] run_d;

  always_comb begin
    sign_d = '0;
    zero_d = '0;
    nar_d  = '0;
    done_d = '0;
    body_d = '0;
    run_d  = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      sign_d[l] = operand_i[l*n + n - 1];
      zero_d[l] = ~|operand_i[l*n +: n];
      nar_d[l]  = sign_d[l] & ~|operand_i[l*n +: n-1];
      body_d[l] = sign_d[l] ? -operand_i[l*n +: n-1] : operand_i[l*n +: n-1];
      for (int unsigned i = 0; i < n - 1; i++) begin
        if (!done_d[l] && (body_d[l][n-2-i] == body_d[l][n-2]))
          run_d[l] = run_d[l] + RW'(1);
        else
          done_d[l] = 1'b1;
      end
    end
  end

  logic [LANES-1:0]         s1_sign, s1_zero, s1_nar;
  logic [LANES-1:0][n-2:0]  s1_body;
  logic [LANES-1:0][RW-1:0] s1_run;

  // Data registers load on accept regardless of flush; the cleared valid bit
  // is what discards a beat taken in a flush cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_sign  <= '0;
      s1_zero  <= '0;
      s1_nar   <= '0;
      s1_body  <= '0;
      s1_run   <= '0;
    end else begin
      if (flush_i)
        s1_valid <= 1'b0;
      else if (s1_adv)
        s1_valid <= in_valid_i;
      if (s1_adv && in_valid_i) begin
        s1_sign <= sign_d;
        s1_zero <= zero_d;
        s1_nar  <= nar_d;
        s1_body <= body_d;
        s1_run  <= run_d;
      end
    end
  end

  // Stage 2 combinational: strip regime and terminator, then split exponent
  // and fraction. Shifting by run+1 also covers the terminator-less case,
  // since the body is then fully shifted out and missing bits read 0.
  logic [LANES-1:0][n-2:0]  rem_d;
  logic [LANES-1:0][SW-1:0] k_d, scale_d;
  logic [LANES-1:0][MW-1:0] mant_d;

  always_comb begin
    rem_d   = '0;
    k_d     = '0;
    scale_d = '0;
    mant_d  = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      rem_d[l]   = (s1_body[l] << s1_run[l]) << 1;
      k_d[l]     = s1_body[l][n-2] ? (SW'(s1_run[l]) - SW'(1))
                                   : (SW'(0) - SW'(s1_run[l]));
      scale_d[l] = (k_d[l] << es) | SW'(rem_d[l] >> (n - 1 - es));
      mant_d[l]  = MW'({1'b1, rem_d[l] << es} >> (n - MW));
      if (s1_zero[l] | s1_nar[l]) begin
        scale_d[l] = '0;
        mant_d[l]  = '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      sign_o      <= '0;
      rg_exp_o    <= '0;
      mant_norm_o <= '0;
      is_zero_o   <= '0;
      is_nar_o    <= '0;
    end else begin
      if (flush_i)
        out_valid_o <= 1'b0;
      else if (s2_adv)
        out_valid_o <= s1_valid;
      if (s2_adv && s1_valid) begin
        sign_o      <= s1_sign;
        rg_exp_o    <= scale_d;
        mant_norm_o <= mant_d;
        is_zero_o   <= s1_zero;
        is_nar_o    <= s1_nar;
      end
    end
  end

endmodule

// File: tb/tb_pdpu_posit_decoder_pipe.sv
// Self-checking bench for pdpu_posit_decoder_pipe (n=16, es=1, LANES=4).
// Expected beats are pushed on accept and compared while presented at the output.
`timescale 1ns/1ps
module tb_pdpu_posit_decoder_pipe;
  localparam int N  = 16;
  localparam int ES = 1;
  localparam int L  = 4;
  localparam int SW = 6;
  localparam int MW = 13;

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [L*N-1:0] operand = '0;
  logic in_ready, out_valid, busy;
  logic [L-1:0] sign, is_zero, is_nar;
  logic [L*SW-1:0] rg_exp;
  logic [L*MW-1:0] mant;

  typedef struct packed {
    logic s; logic [SW-1:0] rg; logic [MW-1:0] m; logic z; logic nr;
  } dec_t;
  typedef struct packed {
    logic [L-1:0][N-1:0] word;
    dec_t [L-1:0]        lane;
  } beat_t;

  beat_t sb[$];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  pdpu_posit_decoder_pipe #(.n(N), .es(ES), .LANES(L)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .operand_i(operand), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .sign_o(sign), .rg_exp_o(rg_exp),
    .mant_norm_o(mant), .is_zero_o(is_zero), .is_nar_o(is_nar), .busy_o(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic dec_t mk(input logic s, input logic [SW-1:0] rg, input logic [MW-1:0] m,
                              input logic z, input logic nr);
    dec_t d;
    d.s = s; d.rg = rg; d.m = m; d.z = z; d.nr = nr;
    return d;
  endfunction

  // Bit-serial reference decode.
  function automatic dec_t golden(input logic [N-1:0] p);
    dec_t d;
    logic [N-2:0] b;
    logic [MW-2:0] f;
    int r, k, e, pos;
    d = '0;
    if (p == 16'h0000) begin d.z = 1'b1; return d; end
    if (p == 16'h8000) begin d.s = 1'b1; d.nr = 1'b1; return d; end
    d.s = p[N-1];
    b = p[N-2:0];
    if (p[N-1]) b = ~b + 15'd1;
    r = 1;
    while (r < N-1 && b[N-2-r] == b[N-2]) r++;
    k = b[N-2] ? r - 1 : -r;
    pos = N - 2 - r - 1;
    e = 0;
    for (int i = 0; i < ES; i++) begin
      e = e * 2;
      if (pos >= 0) begin e = e + int'(b[pos]); pos--; end
    end
    f = '0;
    for (int i = MW-2; i >= 0; i--) begin
      if (pos >= 0) begin f[i] = b[pos]; pos--; end
    end
    d.rg = SW'(k * (1 << ES) + e);
    d.m  = {1'b1, f};
    return d;
  endfunction

  // Rebuild the posit bit string from a decoded result.
  function automatic logic [N-1:0] encode(input dec_t d);
    logic [63:0] acc, tmp;
    logic [N-1:0] res;
    int k, e, len;
    k = int'($signed(d.rg)) >>> ES;
    e = int'(d.rg & SW'((1 << ES) - 1));
    acc = '0; len = 0;
    if (k >= 0) begin
      for (int i = 0; i <= k; i++) begin acc = {acc[62:0], 1'b1}; len++; end
      acc = {acc[62:0], 1'b0}; len++;
    end else begin
      for (int i = 0; i < -k; i++) begin acc = {acc[62:0], 1'b0}; len++; end
      acc = {acc[62:0], 1'b1}; len++;
    end
    for (int i = ES-1; i >= 0; i--) begin acc = {acc[62:0], 1'(e >> i)}; len++; end
    for (int i = MW-2; i >= 0; i--) begin acc = {acc[62:0], d.m[i]}; len++; end
    tmp = (len >= N-1) ? (acc >> (len - (N-1))) : (acc << ((N-1) - len));
    res = {1'b0, tmp[N-2:0]};
    if (d.s) res = ~res + 16'd1;
    return res;
  endfunction

  function automatic beat_t golden_beat(input logic [L*N-1:0] op);
    beat_t b;
    b.word = op;
    for (int l = 0; l < L; l++) b.lane[l] = golden(op[l*N +: N]);
    return b;
  endfunction

  task automatic cycle(input logic v, input logic [L*N-1:0] op, input beat_t exp,
                       input logic ordy, input logic fl, output logic acc);
    in_valid = v; operand = op; out_ready = ordy; flush = fl;
    @(negedge clk);
    check("in_ready", 64'(in_ready), 64'(!(sb.size() == 2 && !ordy)));
    acc = v && in_ready;
    @(posedge clk);
    if (acc && !fl) sb.push_back(exp);
    #1;
    if (fl) sb.delete();
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic drain();
    logic a;
    for (int i = 0; i < 20 && sb.size() != 0; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0, a);
    check("drain_empty", 64'(sb.size()), 64'(0));
  endtask

  // Output monitor: every presented beat must match the oldest outstanding one.
  beat_t mon_e;
  dec_t  mon_o;
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      check("beat_expected", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        mon_e = sb[0];
        for (int l = 0; l < L; l++) begin
          mon_o = {sign[l], rg_exp[l*SW +: SW], mant[l*MW +: MW], is_zero[l], is_nar[l]};
          check($sformatf("lane%0d_decode_%h", l, mon_e.word[l]), 64'(mon_o), 64'(mon_e.lane[l]));
          if (!mon_e.lane[l].z && !mon_e.lane[l].nr)
            check($sformatf("lane%0d_roundtrip", l), 64'(encode(mon_o)), 64'(mon_e.word[l]));
        end
        if (out_ready) begin
          @(posedge clk);
          if (sb.size() != 0) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  logic acc;
  logic [L-1:0][N-1:0] w;
  logic [L*N-1:0] rb [10];
  beat_t eb;
  int idx, cyc;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_data", 64'({sign, is_zero, is_nar}), 64'(0));
    check("rst_rg_exp", 64'(rg_exp), 64'(0));
    check("rst_mant", 64'(mant), 64'(0));

    // Directed beat 1 with latency check
    w = {16'h4800, 16'h5000, 16'hC000, 16'h4000};
    eb.word = w;
    eb.lane[0] = mk(1'b0, 6'd0, 13'h1000, 1'b0, 1'b0);
    eb.lane[1] = mk(1'b1, 6'd0, 13'h1000, 1'b0, 1'b0);
    eb.lane[2] = mk(1'b0, 6'd1, 13'h1000, 1'b0, 1'b0);
    eb.lane[3] = mk(1'b0, 6'd0, 13'h1800, 1'b0, 1'b0);
    cycle(1'b1, w, eb, 1'b1, 1'b0, acc);
    check("t1_accept", 64'(acc), 64'(1));
    check("t1_lat1_invalid", 64'(out_valid), 64'(0));
    cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
    check("t1_lat2_valid", 64'(out_valid), 64'(1));

    // Directed beat 2: specials and extreme regimes
    w = {16'h0001, 16'h7FFF, 16'h8000, 16'h0000};
    eb.word = w;
    eb.lane[0] = mk(1'b0, 6'd0, 13'h0000, 1'b1, 1'b0);
    eb.lane[1] = mk(1'b1, 6'd0, 13'h0000, 1'b0, 1'b1);
    eb.lane[2] = mk(1'b0, 6'd28, 13'h1000, 1'b0, 1'b0);
    eb.lane[3] = mk(1'b0, 6'h24, 13'h1000, 1'b0, 1'b0);
    cycle(1'b1, w, eb, 1'b1, 1'b0, acc);
    drain();

    // Streaming with a stall window on cycles 3..6
    for (int i = 0; i < 10; i++) rb[i] = {$urandom(), $urandom()};
    idx = 0; cyc = 0;
    while (idx < 10 && cyc < 60) begin
      cycle(1'b1, rb[idx], golden_beat(rb[idx]), !(cyc >= 3 && cyc <= 6), 1'b0, acc);
      if (acc) idx++;
      cyc++;
    end
    check("t3_all_accepted", 64'(idx), 64'(10));
    drain();

    // Flush with two beats in flight and input valid (input stalled)
    w = {16'h1234, 16'h2345, 16'h3456, 16'h4567};
    cycle(1'b1, w, golden_beat(w), 1'b0, 1'b0, acc);
    w = {16'hF00D, 16'h0F0F, 16'hA5A5, 16'h5A5A};
    cycle(1'b1, w, golden_beat(w), 1'b0, 1'b0, acc);
    w = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
    cycle(1'b1, w, golden_beat(w), 1'b0, 1'b1, acc);
    check("t4a_busy", 64'(busy), 64'(0));
    check("t4a_out_valid", 64'(out_valid), 64'(0));
    // Flush with one beat in flight and a beat accepted in the same cycle
    w = {16'h7000, 16'h6000, 16'h9000, 16'hB000};
    cycle(1'b1, w, golden_beat(w), 1'b0, 1'b0, acc);
    w = {16'h0100, 16'hFF00, 16'h00FF, 16'h8001};
    cycle(1'b1, w, golden_beat(w), 1'b0, 1'b1, acc);
    check("t4b_flush_accepted", 64'(acc), 64'(1));
    check("t4b_busy", 64'(busy), 64'(0));
    check("t4b_out_valid", 64'(out_valid), 64'(0));
    repeat (3) cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
    w = {16'h6A3C, 16'h9F01, 16'h3C5A, 16'hC3A5};
    cycle(1'b1, w, golden_beat(w), 1'b1, 1'b0, acc);
    drain();

    // Asynchronous reset with a full pipeline
    w = {16'h4321, 16'h8765, 16'h0FED, 16'hCBA9};
    cycle(1'b1, w, golden_beat(w), 1'b0, 1'b0, acc);
    cycle(1'b1, ~w, golden_beat(~w), 1'b0, 1'b0, acc);
    check("t5_full", 64'(out_valid), 64'(1));
    #1 rst = 1'b1;
    #1;
    check("t5_rst_out_valid", 64'(out_valid), 64'(0));
    check("t5_rst_busy", 64'(busy), 64'(0));
    check("t5_rst_data", 64'({sign, rg_exp, mant, is_zero, is_nar}), 64'(0));
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    check("t5_in_ready", 64'(in_ready), 64'(1));
    cycle(1'b1, w, golden_beat(w), 1'b1, 1'b0, acc);
    drain();

    // Exhaustive sweep: every 16-bit pattern appears on exactly one lane
    for (int i = 0; i < 16384; i++) begin
      for (int l = 0; l < L; l++) w[l] = 16'(l * 16384 + i);
      cycle(1'b1, w, golden_beat(w), 1'b1, 1'b0, acc);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
